// File: rtl/ccff_loader.sv
// ccff_loader: streams a word-wide bitstream MSB-first into the fabric
// configuration chain and gates the programming clock while shifting.
//
// Ports:
//   prog_clk, prog_reset   single clock, synchronous active-high reset
//   start, abort           load request pulse / abort level
//   word_valid, word_data  bitstream source word
//   word_ready             word accepted on word_valid & word_ready
//   ccff_head              serial bit into the chain
//   ccff_shift_en          prog clock enable (fabric shifts when high)
//   ccff_tail              chain output (used by the chain check)
//   busy, done, error      status; done and error are sticky
//   bit_count              bits shifted in the current phase
//
// Optional build macro: CCFF_CHAIN_CHECK_EN
//   When defined, each load is preceded by a chain-integrity check that
//   walks a single marker bit through the chain and times its arrival
//   at ccff_tail.

module ccff_loader #(
    parameter int BITSTREAM_SIZE = 29696,
    parameter int WORD_W         = 32,
    parameter int CNT_W          = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int WB_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(BITSTREAM_SIZE);
    localparam logic [WB_W-1:0]  WLAST  = WB_W'(WORD_W - 1);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_ABORT = 2'd1;
`ifdef CCFF_CHAIN_CHECK_EN
    localparam logic [1:0] E_LEN   = 2'd2;
    localparam logic [1:0] E_EARLY = 2'd3;

    // Marker still missing two shifts past the expected length.
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(BITSTREAM_SIZE + 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
`ifdef CCFF_CHAIN_CHECK_EN
        ,
        S_CHK_MARK,
        S_CHK_WAIT
`endif
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   wbit;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc = bit_count + 1'b1;

`ifndef CCFF_CHAIN_CHECK_EN
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state         <= S_IDLE;
            word_ready    <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= E_NONE;
            bit_count     <= '0;
            shreg         <= '0;
            wbit          <= '0;
        end else if (abort && state != S_IDLE) begin
            state         <= S_IDLE;
            word_ready    <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            error         <= E_ABORT;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= E_NONE;
                        bit_count <= '0;
`ifdef CCFF_CHAIN_CHECK_EN
                        state         <= S_CHK_MARK;
                        ccff_head     <= 1'b1;
                        ccff_shift_en <= 1'b1;
`else
                        state      <= S_LOAD;
                        word_ready <= 1'b1;
`endif
                    end
                end

`ifdef CCFF_CHAIN_CHECK_EN
                S_CHK_MARK: begin
                    state     <= S_CHK_WAIT;
                    ccff_head <= 1'b0;
                    bit_count <= cnt_inc;
                end

                S_CHK_WAIT: begin
                    // bit_count equals the shifts done so far, so the
                    // marker reaches a correct tail when it hits SIZE.
                    if (ccff_tail) begin
                        ccff_shift_en <= 1'b0;
                        if (bit_count >= SIZE_C) begin
                            state      <= S_LOAD;
                            word_ready <= 1'b1;
                            bit_count  <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            error <= E_EARLY;
                        end
                    end else if (bit_count == LIMIT_C) begin
                        state         <= S_IDLE;
                        ccff_shift_en <= 1'b0;
                        busy          <= 1'b0;
                        error         <= E_LEN;
                    end else begin
                        bit_count <= cnt_inc;
                    end
                end
`endif

                S_LOAD: begin
                    if (word_valid) begin
                        state         <= S_SHIFT;
                        word_ready    <= 1'b0;
                        ccff_shift_en <= 1'b1;
                        ccff_head     <= word_data[WORD_W-1];
                        shreg         <= word_data << 1;
                        wbit          <= '0;
                    end
                end

                S_SHIFT: begin
                    // the bit on ccff_head is taken by the fabric at
                    // this edge; count it and present the next one
                    bit_count <= cnt_inc;
                    if (cnt_inc == SIZE_C) begin
                        state         <= S_DONE;
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (wbit == WLAST) begin
                        state         <= S_LOAD;
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                        word_ready    <= 1'b1;
                    end else begin
                        ccff_head <= shreg[WORD_W-1];
                        shreg     <= shreg << 1;
                        wbit      <= wbit + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for ccff_loader with a full-size
// instance and a 40-bit instance, each driving a serial chain model.

module tb_ccff_loader;

    localparam int BIG_N = 29696;
    localparam int SML_N = 40;
    localparam int W     = 32;
    localparam int CW    = 16;

    localparam logic [W-1:0]  PAT   = 32'hA5A5A5A5;
    localparam logic [W-1:0]  S_W0  = 32'hFFFFFFFF;
    localparam logic [W-1:0]  S_W1  = 32'hC0000000;
    localparam logic [39:0]   S_EXP = 40'hFFFFFFFFC0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int total;
    int bad;

    // full-size instance
    logic          b_start, b_abort, b_valid;
    logic [W-1:0]  b_data;
    logic          b_ready, b_head, b_shen, b_tail, b_busy, b_done;
    logic [1:0]    b_err;
    logic [CW-1:0] b_cnt;

    // 40-bit instance
    logic          s_start, s_abort, s_valid;
    logic [W-1:0]  s_data;
    logic          s_ready, s_head, s_shen, s_tail, s_busy, s_done;
    logic [1:0]    s_err;
    logic [CW-1:0] s_cnt;

    ccff_loader #(
        .BITSTREAM_SIZE(BIG_N), .WORD_W(W), .CNT_W(CW)
    ) u_big (
        .prog_clk(clk), .prog_reset(rst),
        .start(b_start), .abort(b_abort),
        .word_valid(b_valid), .word_data(b_data),
        .word_ready(b_ready), .ccff_head(b_head),
        .ccff_shift_en(b_shen), .ccff_tail(b_tail),
        .busy(b_busy), .done(b_done), .error(b_err),
        .bit_count(b_cnt)
    );

    ccff_loader #(
        .BITSTREAM_SIZE(SML_N), .WORD_W(W), .CNT_W(CW)
    ) u_sml (
        .prog_clk(clk), .prog_reset(rst),
        .start(s_start), .abort(s_abort),
        .word_valid(s_valid), .word_data(s_data),
        .word_ready(s_ready), .ccff_head(s_head),
        .ccff_shift_en(s_shen), .ccff_tail(s_tail),
        .busy(s_busy), .done(s_done), .error(s_err),
        .bit_count(s_cnt)
    );

    // full-size chain and head-sequence checker
    logic [BIG_N-1:0] b_chain;
    logic             b_clr;
    int               b_shifts, b_herr, b_acc;

    assign b_data = PAT;
    assign b_tail = b_chain[BIG_N-1];

    always @(posedge clk) begin
        if (b_clr) begin
            b_chain  <= '0;
            b_shifts <= 0;
            b_herr   <= 0;
            b_acc    <= 0;
        end else begin
            if (b_shen) begin
                b_chain <= {b_chain[BIG_N-2:0], b_head};
                if (b_acc > 0) begin
                    if (b_head !== PAT[31 - (b_shifts % 32)])
                        b_herr <= b_herr + 1;
                    b_shifts <= b_shifts + 1;
                end
            end
            if (b_valid && b_ready)
                b_acc <= b_acc + 1;
        end
    end

    // 40-bit source, variable-length chain and head recorder
    logic [63:0] s_chain;
    logic [63:0] s_seq;
    int          s_len, s_idx, s_nbits;
    logic        s_stuck, s_clr, s_saw_ready;

    assign s_data = (s_idx == 0) ? S_W0 : S_W1;
    assign s_tail = s_stuck ? 1'b0 : s_chain[s_len-1];

    always @(posedge clk) begin
        if (s_clr) begin
            s_chain     <= '0;
            s_seq       <= '0;
            s_idx       <= 0;
            s_nbits     <= 0;
            s_saw_ready <= 1'b0;
        end else begin
            if (s_shen)
                s_chain <= {s_chain[62:0], s_head};
            if (s_shen && s_idx > 0) begin
                s_seq   <= {s_seq[62:0], s_head};
                s_nbits <= s_nbits + 1;
            end
            if (s_valid && s_ready)
                s_idx <= s_idx + 1;
            if (s_ready)
                s_saw_ready <= 1'b1;
        end
    end

    task automatic b_clear();
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
    endtask

    task automatic s_clear();
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
    endtask

    task automatic s_go();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic s_wait_done();
        for (int i = 0; i < 400 && !s_done; i++)
            @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({b_ready, b_head, b_shen, b_busy, b_done, b_err, b_cnt}
            !== '0) begin
            bad++;
            $display("FAIL reset_big got=%b want=0",
                {b_ready, b_head, b_shen, b_busy, b_done, b_err, b_cnt});
        end
        total++;
        if ({s_ready, s_head, s_shen, s_busy, s_done, s_err, s_cnt}
            !== '0) begin
            bad++;
            $display("FAIL reset_sml got=%b want=0",
                {s_ready, s_head, s_shen, s_busy, s_done, s_err, s_cnt});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        b_clear();
        b_valid = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
`ifndef CCFF_CHAIN_CHECK_EN
        repeat (928 * 33 + 1) @(negedge clk);
`else
        for (int i = 0; i < 70000 && !b_done; i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
`endif
        total++;
        if (b_done !== 1'b1 || b_err !== 2'd0) begin
            bad++;
            $display("FAIL full_done got=%b/%0d want=1/0", b_done, b_err);
        end
        total++;
        if (b_busy !== 1'b0) begin
            bad++;
            $display("FAIL full_busy got=%b want=0", b_busy);
        end
        total++;
        if (b_cnt !== 16'(BIG_N)) begin
            bad++;
            $display("FAIL full_cnt got=%0d want=%0d", b_cnt, BIG_N);
        end
        total++;
        if (b_shifts != BIG_N) begin
            bad++;
            $display("FAIL full_shifts got=%0d want=%0d", b_shifts, BIG_N);
        end
        total++;
        if (b_herr != 0) begin
            bad++;
            $display("FAIL full_head got=%0d want=0", b_herr);
        end
        total++;
        if (b_acc != 928) begin
            bad++;
            $display("FAIL full_words got=%0d want=928", b_acc);
        end
        total++;
        if (b_tail !== 1'b1) begin
            bad++;
            $display("FAIL full_tail got=%b want=1", b_tail);
        end
    endtask

    task automatic test_abort();
        b_clear();
        b_valid = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 2000 && b_cnt != 16'd100; i++)
            @(negedge clk);
        total++;
        if (b_cnt !== 16'd100) begin
            bad++;
            $display("FAIL abort_reach got=%0d want=100", b_cnt);
        end
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        total++;
        if ({b_shen, b_busy, b_ready, b_head, b_err}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd1}) begin
            bad++;
            $display("FAIL abort_out got=%b%b%b%b/%0d want=0000/1",
                b_shen, b_busy, b_ready, b_head, b_err);
        end
        // abort together with start while idle: start is ignored
        b_start = 1'b1;
        b_abort = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_abort = 1'b0;
        @(negedge clk);
        total++;
        if (b_busy !== 1'b0 || b_err !== 2'd1) begin
            bad++;
            $display("FAIL abort_start got=%b/%0d want=0/1", b_busy, b_err);
        end
        b_clear();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        total++;
        if (b_err !== 2'd0 || b_busy !== 1'b1 || b_cnt !== 16'd0) begin
            bad++;
            $display("FAIL restart got=%0d/%b/%0d want=0/1/0",
                b_err, b_busy, b_cnt);
        end
`ifndef CCFF_CHAIN_CHECK_EN
        repeat (39) @(negedge clk);
        total++;
        if (b_shifts != 37 || b_herr != 0 || b_cnt !== 16'd37) begin
            bad++;
            $display("FAIL reload got=%0d/%0d/%0d want=37/0/37",
                b_shifts, b_herr, b_cnt);
        end
`endif
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_partial_word();
        s_len   = SML_N;
        s_stuck = 1'b0;
        s_valid = 1'b1;
        s_clear();
        s_go();
        s_wait_done();
        total++;
        if (s_done !== 1'b1 || s_err !== 2'd0) begin
            bad++;
            $display("FAIL part_done got=%b/%0d want=1/0", s_done, s_err);
        end
        total++;
        if (s_cnt !== 16'd40 || s_nbits != 40) begin
            bad++;
            $display("FAIL part_cnt got=%0d/%0d want=40/40", s_cnt, s_nbits);
        end
        total++;
        if (s_seq[39:0] !== S_EXP) begin
            bad++;
            $display("FAIL part_seq got=%h want=%h", s_seq[39:0], S_EXP);
        end
        total++;
        if (s_idx != 2) begin
            bad++;
            $display("FAIL part_words got=%0d want=2", s_idx);
        end
    endtask

    task automatic test_stall();
        int stall_err;
        stall_err = 0;
        s_valid = 1'b1;
        s_clear();
        s_go();
        for (int i = 0; i < 200 && s_idx == 0; i++)
            @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 100 && !s_ready; i++)
            @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (s_shen !== 1'b0 || s_ready !== 1'b1)
                stall_err++;
            @(negedge clk);
        end
        total++;
        if (stall_err != 0 || s_nbits != 32) begin
            bad++;
            $display("FAIL stall_hold got=%0d/%0d want=0/32",
                stall_err, s_nbits);
        end
        s_valid = 1'b1;
        s_wait_done();
        total++;
        if (s_seq[39:0] !== S_EXP || s_cnt !== 16'd40) begin
            bad++;
            $display("FAIL stall_seq got=%h/%0d want=%h/40",
                s_seq[39:0], s_cnt, S_EXP);
        end
    endtask

    task automatic test_start_busy();
        logic [CW-1:0] c;
        s_valid = 1'b1;
        s_clear();
        s_go();
        for (int i = 0; i < 200 && !(s_shen && s_idx > 0); i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        c = s_cnt;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        total++;
        if (s_cnt !== c + 16'd1 || s_busy !== 1'b1 || s_done !== 1'b0) begin
            bad++;
            $display("FAIL busy_start got=%0d/%b/%b want=%0d/1/0",
                s_cnt, s_busy, s_done, c + 16'd1);
        end
        s_wait_done();
        total++;
        if (s_seq[39:0] !== S_EXP || s_cnt !== 16'd40) begin
            bad++;
            $display("FAIL busy_seq got=%h/%0d want=%h/40",
                s_seq[39:0], s_cnt, S_EXP);
        end
    endtask

    task automatic test_reset_mid();
        s_valid = 1'b1;
        s_clear();
        s_go();
        for (int i = 0; i < 200 && !(s_shen && s_idx > 0); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (s_shen !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got=%b want=1", s_shen);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({s_ready, s_head, s_shen, s_busy, s_done, s_err, s_cnt}
            !== '0) begin
            bad++;
            $display("FAIL rst_mid got=%b want=0",
                {s_ready, s_head, s_shen, s_busy, s_done, s_err, s_cnt});
        end
        s_valid = 1'b0;
        @(negedge clk);
    endtask

`ifdef CCFF_CHAIN_CHECK_EN
    task automatic test_chain_check();
        s_valid = 1'b1;
        s_len   = SML_N - 1;
        s_stuck = 1'b0;
        s_clear();
        s_go();
        for (int i = 0; i < 200 && s_busy; i++)
            @(negedge clk);
        total++;
        if (s_err !== 2'd3 || s_cnt !== 16'd39 || s_saw_ready !== 1'b0) begin
            bad++;
            $display("FAIL chk_short got=%0d/%0d/%b want=3/39/0",
                s_err, s_cnt, s_saw_ready);
        end
        s_len   = SML_N;
        s_stuck = 1'b1;
        s_clear();
        s_go();
        for (int i = 0; i < 200 && s_busy; i++)
            @(negedge clk);
        total++;
        if (s_err !== 2'd2 || s_cnt !== 16'd42 || s_saw_ready !== 1'b0) begin
            bad++;
            $display("FAIL chk_broken got=%0d/%0d/%b want=2/42/0",
                s_err, s_cnt, s_saw_ready);
        end
        s_stuck = 1'b0;
        s_clear();
        s_go();
        s_wait_done();
        total++;
        if (s_done !== 1'b1 || s_err !== 2'd0 || s_seq[39:0] !== S_EXP) begin
            bad++;
            $display("FAIL chk_pass got=%b/%0d/%h want=1/0/%h",
                s_done, s_err, s_seq[39:0], S_EXP);
        end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        b_start = 1'b0;
        b_abort = 1'b0;
        b_valid = 1'b0;
        b_clr   = 1'b1;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_valid = 1'b0;
        s_clr   = 1'b1;
        s_len   = SML_N;
        s_stuck = 1'b0;
        @(negedge clk);
        b_clr = 1'b0;
        s_clr = 1'b0;

        test_reset();
        test_full_load();
        test_abort();
        test_partial_word();
        test_stall();
        test_start_busy();
        test_reset_mid();
`ifdef CCFF_CHAIN_CHECK_EN
        test_chain_check();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
